// File: rtl/apb_master.sv
// APB requester: command/response handshake to APB SETUP/ACCESS transfers,
// with PREADY wait states, PSLVERR capture and a wait-state abort limit.
module apb_master #(
    parameter int AWIDTH  = 4,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CMAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          done;
    logic          abort;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (TIMEOUT != 0 && cnt == LIMIT) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // PSEL/PENABLE are registered images of the next state
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else begin
            state   <= state_n;
            PSEL    <= (state_n != IDLE);
            PENABLE <= (state_n == ACCESS);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= done | abort;
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
                cnt    <= '0;
            end else if (state == ACCESS && !PREADY && cnt != CMAX) begin
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                rsp_err     <= PSLVERR;
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_err     <= 1'b1;
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: vector table, randomized transfers against a
// behavioural model, and reset / back-to-back sequences.
module tb_apb_master;

    localparam int TO = 4;

    logic       PCLK;
    logic       PRESETn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    apb_master #(
        .AWIDTH (4),
        .DWIDTH (8),
        .TIMEOUT(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic       slverr;
        logic       pulse;
        logic [7:0] prdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_to;
        int         exp_acc;
    } vec_t;

    vec_t       vecs[7];
    int         checks;
    int         errors;
    logic [7:0] last_rdata;
    logic       last_err;
    logic       last_to;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Outcome derived from the transfer rules, not from the design
    function automatic void model(inout vec_t v);
        if (TO != 0 && v.waits >= TO) begin
            v.exp_rdata = 8'h00;
            v.exp_err   = 1'b1;
            v.exp_to    = 1'b1;
            v.exp_acc   = TO;
        end else begin
            v.exp_rdata = v.wr ? 8'h00 : v.prdata;
            v.exp_err   = v.slverr;
            v.exp_to    = 1'b0;
            v.exp_acc   = v.waits + 1;
        end
    endfunction

    task automatic xfer(input vec_t v);
        int  n_acc;
        bit  seen;
        @(negedge PCLK);
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("rsp_hold", 32'({rsp_timeout, rsp_err, rsp_rdata}),
            32'({last_to, last_err, last_rdata}));
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        PRDATA    = v.prdata;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = 8'($urandom);
        chk("setup", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}),
            32'({1'b1, 1'b0, v.wr, v.addr, v.wdata}));
        n_acc = 0;
        seen  = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                seen = 1;
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                chk("rsp_psel", 32'({PSEL, PENABLE}), 32'd0);
                chk("n_access", 32'(n_acc), 32'(v.exp_acc));
                chk("rsp_data", 32'(rsp_rdata), 32'(v.exp_rdata));
                chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
                chk("rsp_to", 32'(rsp_timeout), 32'(v.exp_to));
                chk("addr_hold", 32'({PWRITE, PADDR, PWDATA}),
                    32'({v.wr, v.addr, v.wdata}));
                last_rdata = v.exp_rdata;
                last_err   = v.exp_err;
                last_to    = v.exp_to;
            end else begin
                chk("access", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}),
                    32'({1'b1, 1'b1, v.wr, v.addr, v.wdata}));
                PREADY  = (n_acc == v.waits);
                PSLVERR = PREADY ? v.slverr : v.pulse;
                n_acc++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL rsp_wait: got no rsp_valid want rsp_valid");
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   idx;
        int   rsp_idx;
        int   last_setup;
        checks     = 0;
        errors     = 0;
        last_rdata = 8'h00;
        last_err   = 1'b0;
        last_to    = 1'b0;
        //          wr   addr   wdata  wt slv  pls  prdata exp_rd ee   et   acc
        vecs[0] = '{1'b1, 4'h3, 8'h5A, 0, 1'b0, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 4'h6, 8'h00, 2, 1'b0, 1'b0, 8'hC3, 8'hC3, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 4'h1, 8'h00, 0, 1'b1, 1'b0, 8'h11, 8'h11, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 4'h2, 8'h00, 2, 1'b0, 1'b1, 8'h22, 8'h22, 1'b0, 1'b0, 3};
        vecs[4] = '{1'b0, 4'h7, 8'h00, 10, 1'b0, 1'b0, 8'h99, 8'h00, 1'b1, 1'b1, 4};
        vecs[5] = '{1'b1, 4'h9, 8'hA5, 1, 1'b0, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 2};
        vecs[6] = '{1'b1, 4'hE, 8'h3C, 3, 1'b1, 1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 4};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 8'h00;
        PRDATA    = 8'h00;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("reset_state", 32'({cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                                rsp_valid, rsp_rdata, rsp_err, rsp_timeout}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00,
                 1'b0, 8'h00, 1'b0, 1'b0}));
        PRESETn = 1'b1;

        foreach (vecs[i]) xfer(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            rv.wr     = 1'($urandom);
            rv.addr   = 4'($urandom);
            rv.wdata  = 8'($urandom);
            rv.waits  = int'($urandom_range(0, 6));
            rv.slverr = 1'($urandom);
            rv.pulse  = 1'($urandom);
            rv.prdata = 8'($urandom);
            model(rv);
            xfer(rv);
        end

        // Reset in the middle of a stalled read
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'h5;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("pre_reset_access", 32'({PSEL, PENABLE}), 32'd3);
        PRESETn = 1'b0;
        #1;
        chk("async_drop", 32'({PSEL, PENABLE}), 32'd0);
        repeat (2) begin
            @(negedge PCLK);
            chk("reset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        PRESETn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            chk("post_reset", 32'({cmd_ready, PSEL, PENABLE, PWRITE, PADDR,
                                   PWDATA, rsp_valid, rsp_rdata, rsp_err,
                                   rsp_timeout}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00,
                     1'b0, 8'h00, 1'b0, 1'b0}));
        end
        last_rdata = 8'h00;
        last_err   = 1'b0;
        last_to    = 1'b0;

        // Four writes queued with cmd_valid held high
        PREADY     = 1'b1;
        PSLVERR    = 1'b0;
        idx        = 0;
        rsp_idx    = 0;
        last_setup = 0;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'h0;
        cmd_wdata = 8'h10;
        for (int c = 0; c < 30 && rsp_idx < 4; c++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) begin
                chk("q_setup", 32'({PWRITE, PADDR, PWDATA}),
                    32'({1'b1, 4'(idx), 8'(8'h10 + idx)}));
                if (idx > 0) chk("q_spacing", 32'(c - last_setup), 32'd3);
                last_setup = c;
                idx++;
                if (idx == 4) begin
                    cmd_valid = 1'b0;
                end else begin
                    cmd_addr  = 4'(idx);
                    cmd_wdata = 8'(8'h10 + idx);
                end
            end
            if (rsp_valid) begin
                chk("q_order", 32'(PADDR), 32'(rsp_idx));
                chk("q_err", 32'({rsp_err, rsp_timeout, rsp_rdata}), 32'd0);
                rsp_idx++;
            end
        end
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        chk("q_count", 32'(rsp_idx), 32'd4);

        xfer(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
